conv2d_engine: RTL and testbench

CONV2D_ENGINE -- requirements
Module: conv2d_engine

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/mac_unit.sv | 28 ++
 rtl/conv2d_engine.sv | 117 +++++++++++
 tb/tb_conv2d_engine.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and fixed-point helpers for the CNN engines
package cnn_pkg;

   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

   // Wide enough to sum KSIZE*KSIZE full-scale products without overflow.
   function automatic int acc_width(input int wbits, input int ksize);
      return 2 * wbits + $clog2(ksize * ksize);
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int wbits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (wbits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (wbits - 1));
      if (v > hi)
         return hi;
      else if (v < lo)
         return lo;
      else
         return v;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - registered signed multiply-accumulate with clear and enable
module mac_unit #(
   parameter int WIDTH_BIT = 16,
   parameter int ACC_W     = 37
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        enable,
   input  logic signed [WIDTH_BIT-1:0] a,
   input  logic signed [WIDTH_BIT-1:0] b,
   output logic signed [ACC_W-1:0]     acc
);

   logic signed [2*WIDTH_BIT-1:0] product;

   assign product = a * b;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         acc <= '0;
      else if (clear)
         acc <= '0;
      else if (enable)
         acc <= acc + ACC_W'(product);
   end

endmodule

// File: rtl/conv2d_engine.sv
// rtl/conv2d_engine.sv - sequential valid-mode 2-D convolution, one MAC per cycle
import cnn_pkg::*;

module conv2d_engine #(
   parameter int SIZE      = 28,
   parameter int KSIZE     = 5,
   parameter int WIDTH_BIT = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic signed [WIDTH_BIT-1:0] image   [SIZE-1:0][SIZE-1:0],
   input  logic signed [WIDTH_BIT-1:0] kernel  [KSIZE-1:0][KSIZE-1:0],
   output logic                        busy,
   output logic                        done,
   output logic signed [WIDTH_BIT-1:0] convOut [SIZE-KSIZE:0][SIZE-KSIZE:0]
);

   localparam int OUT   = SIZE - KSIZE + 1;
   localparam int ACC_W = acc_width(WIDTH_BIT, KSIZE);
   localparam int CW    = (SIZE  > 1) ? $clog2(SIZE)  : 1;
   localparam int OW    = (OUT   > 1) ? $clog2(OUT)   : 1;
   localparam int KW    = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam logic [KW-1:0] KLAST = KW'(KSIZE - 1);
   localparam logic [OW-1:0] OLAST = OW'(OUT - 1);

   state_t                 state;
   logic [OW-1:0]          i, j;
   logic [KW-1:0]          ki, kj;
   logic [CW-1:0]          row, col;
   logic                   mac_clear, mac_enable;
   logic signed [ACC_W-1:0] acc, acc_shr;
   logic signed [63:0]     acc_sat;

   assign row        = CW'(i) + CW'(ki);
   assign col        = CW'(j) + CW'(kj);
   assign mac_enable = (state == MAC);
   assign mac_clear  = (state == WRITE) || (((state == IDLE) || (state == DONE)) && start);
   assign acc_shr    = acc >>> FRAC_BITS;
   assign acc_sat    = saturate(64'(acc_shr), WIDTH_BIT);

   mac_unit #(
      .WIDTH_BIT(WIDTH_BIT),
      .ACC_W    (ACC_W)
   ) u_mac (
      .clock (clock),
      .reset (reset),
      .clear (mac_clear),
      .enable(mac_enable),
      .a     (image[row][col]),
      .b     (kernel[ki][kj]),
      .acc   (acc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
         ki    <= '0;
         kj    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++)
               convOut[r][c] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state <= MAC;
                  i     <= '0;
                  j     <= '0;
                  ki    <= '0;
                  kj    <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            MAC: begin
               if (kj == KLAST) begin
                  kj <= '0;
                  if (ki == KLAST) begin
                     ki    <= '0;
                     state <= WRITE;
                  end else begin
                     ki <= ki + KW'(1);
                  end
               end else begin
                  kj <= kj + KW'(1);
               end
            end
            WRITE: begin
               convOut[i][j] <= acc_sat[WIDTH_BIT-1:0];
               if (j == OLAST) begin
                  j <= '0;
                  if (i == OLAST) begin
                     i     <= '0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     i     <= i + OW'(1);
                     state <= MAC;
                  end
               end else begin
                  j     <= j + OW'(1);
                  state <= MAC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv2d_engine.sv
// tb/tb_conv2d_engine.sv - randomized self-checking bench against a direct convolution model
module tb_conv2d_engine;

   localparam int SIZE  = 6;
   localparam int KSIZE = 3;
   localparam int OUT   = SIZE - KSIZE + 1;
   localparam int W     = 16;
   localparam int LAT   = OUT * OUT * (KSIZE * KSIZE + 1);

   logic clock = 1'b0;
   logic reset;
   logic start0, start8;
   logic busy0, busy8, done0, done8;
   logic signed [W-1:0] img   [SIZE-1:0][SIZE-1:0];
   logic signed [W-1:0] ker   [KSIZE-1:0][KSIZE-1:0];
   logic signed [W-1:0] out0  [OUT-1:0][OUT-1:0];
   logic signed [W-1:0] out8  [OUT-1:0][OUT-1:0];
   logic signed [W-1:0] expv  [OUT-1:0][OUT-1:0];
   logic signed [W-1:0] saved [OUT-1:0][OUT-1:0];

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   conv2d_engine #(.SIZE(SIZE), .KSIZE(KSIZE), .WIDTH_BIT(W), .FRAC_BITS(0)) dut0 (
      .clock(clock), .reset(reset), .start(start0), .image(img), .kernel(ker),
      .busy(busy0), .done(done0), .convOut(out0)
   );

   conv2d_engine #(.SIZE(SIZE), .KSIZE(KSIZE), .WIDTH_BIT(W), .FRAC_BITS(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .image(img), .kernel(ker),
      .busy(busy8), .done(done8), .convOut(out8)
   );

   function automatic logic signed [W-1:0] get_out(input int d, input int r, input int c);
      return (d == 0) ? out0[r][c] : out8[r][c];
   endfunction

   function automatic logic get_busy(input int d);
      return (d == 0) ? busy0 : busy8;
   endfunction

   function automatic logic get_done(input int d);
      return (d == 0) ? done0 : done8;
   endfunction

   task automatic set_start(input int d, input logic v);
      if (d == 0) start0 = v;
      else        start8 = v;
   endtask

   // Direct valid-mode convolution, floor shift, clamp to the signed range.
   task automatic model(input int frac);
      for (int i = 0; i < OUT; i++)
         for (int j = 0; j < OUT; j++) begin
            longint s = 0;
            for (int ki = 0; ki < KSIZE; ki++)
               for (int kj = 0; kj < KSIZE; kj++)
                  s += longint'(img[i+ki][j+kj]) * longint'(ker[ki][kj]);
            s = s >>> frac;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            expv[i][j] = W'(s);
         end
   endtask

   task automatic fill(input int ilo, input int ihi, input int klo, input int khi);
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            img[r][c] = W'(int'($urandom_range(ihi - ilo)) + ilo);
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            ker[r][c] = W'(int'($urandom_range(khi - klo)) + klo);
   endtask

   task automatic fill_const(input int iv, input int kv);
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            img[r][c] = W'(iv);
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            ker[r][c] = W'(kv);
   endtask

   // edges counts the start-sampling edge as 1; busy_cnt counts busy cycles.
   task automatic run(input int d, input int restart_at, output int edges, output int busy_cnt);
      @(negedge clock);
      set_start(d, 1'b1);
      @(posedge clock);
      edges    = 1;
      busy_cnt = 0;
      @(negedge clock);
      set_start(d, 1'b0);
      while (!get_done(d) && edges < 1000) begin
         if (get_busy(d)) busy_cnt++;
         set_start(d, edges == restart_at);
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      set_start(d, 1'b0);
   endtask

   task automatic test_reset;
      @(negedge clock);
      n_cmp++;
      if (busy0 !== 1'b0 || done0 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy0=%b done0=%b busy8=%b done8=%b, required all 0",
                  busy0, done0, busy8, done8);
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== 16'sd0 || out8[r][c] !== 16'sd0) begin
               n_fail++;
               $display("FAIL reset_out[%0d][%0d]: got %0d/%0d, required 0", r, c,
                        out0[r][c], out8[r][c]);
            end
         end
      reset = 1'b0;
   endtask

   task automatic test_ones;
      int e, b;
      fill_const(1, 1);
      run(0, -1, e, b);
      n_cmp++;
      if (e !== LAT + 1) begin
         n_fail++;
         $display("FAIL ones_latency: done after %0d edges, required %0d", e, LAT + 1);
      end
      n_cmp++;
      if (b !== LAT) begin
         n_fail++;
         $display("FAIL ones_busy: busy %0d cycles, required %0d", b, LAT);
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== 16'sd9) begin
               n_fail++;
               $display("FAIL ones_out[%0d][%0d]: got %0d, required 9", r, c, out0[r][c]);
            end
         end
   endtask

   task automatic test_identity;
      int e, b;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            img[r][c] = W'(r * SIZE + c);
      fill_const_kernel_zero();
      ker[1][1] = 16'sd1;
      run(0, -1, e, b);
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== W'((r + 1) * SIZE + (c + 1))) begin
               n_fail++;
               $display("FAIL identity_out[%0d][%0d]: got %0d, required %0d", r, c,
                        out0[r][c], (r + 1) * SIZE + (c + 1));
            end
         end
   endtask

   task automatic fill_const_kernel_zero;
      for (int r = 0; r < KSIZE; r++)
         for (int c = 0; c < KSIZE; c++)
            ker[r][c] = 16'sd0;
   endtask

   task automatic test_saturation;
      int e, b;
      fill_const(32767, 32767);
      run(0, -1, e, b);
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== 16'sd32767) begin
               n_fail++;
               $display("FAIL sat_pos[%0d][%0d]: got %0d, required 32767", r, c, out0[r][c]);
            end
         end
      fill_const(32767, -32768);
      run(0, -1, e, b);
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== -16'sd32768) begin
               n_fail++;
               $display("FAIL sat_neg[%0d][%0d]: got %0d, required -32768", r, c, out0[r][c]);
            end
         end
   endtask

   task automatic test_frac;
      int e, b;
      fill_const(256, 128);
      run(1, -1, e, b);
      n_cmp++;
      if (e !== LAT + 1) begin
         n_fail++;
         $display("FAIL frac_latency: done after %0d edges, required %0d", e, LAT + 1);
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out8[r][c] !== 16'sd1152) begin
               n_fail++;
               $display("FAIL frac_out[%0d][%0d]: got %0d, required 1152", r, c, out8[r][c]);
            end
         end
   endtask

   task automatic test_random;
      int e, b;
      for (int round = 0; round < 8; round++) begin
         int d;
         d = round % 2;
         if (round < 4) fill(-300, 300, -300, 300);
         else           fill(-32768, 32767, -32768, 32767);
         model(d == 0 ? 0 : 8);
         run(d, -1, e, b);
         n_cmp++;
         if (e !== LAT + 1) begin
            n_fail++;
            $display("FAIL random_latency round %0d: done after %0d edges, required %0d",
                     round, e, LAT + 1);
         end
         for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++) begin
               n_cmp++;
               if (get_out(d, r, c) !== expv[r][c]) begin
                  n_fail++;
                  $display("FAIL random_out round %0d [%0d][%0d]: got %0d, required %0d",
                           round, r, c, get_out(d, r, c), expv[r][c]);
               end
            end
      end
   endtask

   task automatic test_back_to_back;
      int e, b, n;
      fill(-500, 500, -50, 50);
      model(0);
      run(0, 50, e, b);
      n_cmp++;
      if (e !== LAT + 1) begin
         n_fail++;
         $display("FAIL restart_ignored_latency: done after %0d edges, required %0d", e, LAT + 1);
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== expv[r][c]) begin
               n_fail++;
               $display("FAIL restart_ignored_out[%0d][%0d]: got %0d, required %0d", r, c,
                        out0[r][c], expv[r][c]);
            end
         end
      repeat (3) @(negedge clock);
      n_cmp++;
      if (done0 !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL done_hold: done=%b busy=%b, required done=1 busy=0", done0, busy0);
      end
      // Second run from DONE reproduces the same map.
      start0 = 1'b1;
      @(posedge clock);
      #1;
      n_cmp++;
      if (done0 !== 1'b0 || busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL done_fall: done=%b busy=%b, required done=0 busy=1", done0, busy0);
      end
      @(negedge clock);
      start0 = 1'b0;
      n = 0;
      while (!done0 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== expv[r][c]) begin
               n_fail++;
               $display("FAIL rerun_out[%0d][%0d]: got %0d, required %0d", r, c,
                        out0[r][c], expv[r][c]);
            end
         end
      // New image: only entry [0][0] is rewritten after the first pixel period.
      saved = expv;
      fill(-500, 500, -50, 50);
      model(0);
      start0 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start0 = 1'b0;
      repeat (KSIZE * KSIZE + 1) @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (out0[0][0] !== expv[0][0] || out0[0][1] !== saved[0][1] ||
          out0[OUT-1][OUT-1] !== saved[OUT-1][OUT-1]) begin
         n_fail++;
         $display("FAIL partial_keep: got %0d,%0d,%0d, required %0d,%0d,%0d",
                  out0[0][0], out0[0][1], out0[OUT-1][OUT-1],
                  expv[0][0], saved[0][1], saved[OUT-1][OUT-1]);
      end
      n = 0;
      while (!done0 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      n_cmp++;
      if (done0 !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_done: done=%b after %0d cycles, required 1", done0, n);
      end
   endtask

   task automatic test_reset_midrun;
      int e, b, seen;
      fill(-1000, 1000, -100, 100);
      model(0);
      @(negedge clock);
      start0 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start0 = 1'b0;
      repeat (69) @(posedge clock);
      @(negedge clock);
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_flags: busy=%b done=%b, required 0 0", busy0, done0);
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== 16'sd0) begin
               n_fail++;
               $display("FAIL midreset_out[%0d][%0d]: got %0d, required 0", r, c, out0[r][c]);
            end
         end
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      seen = 0;
      repeat (200) begin
         @(negedge clock);
         if (done0 || busy0) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL midreset_idle: busy/done seen %0d cycles, required 0", seen);
      end
      run(0, -1, e, b);
      n_cmp++;
      if (e !== LAT + 1) begin
         n_fail++;
         $display("FAIL midreset_latency: done after %0d edges, required %0d", e, LAT + 1);
      end
      for (int r = 0; r < OUT; r++)
         for (int c = 0; c < OUT; c++) begin
            n_cmp++;
            if (out0[r][c] !== expv[r][c]) begin
               n_fail++;
               $display("FAIL midreset_out_after[%0d][%0d]: got %0d, required %0d", r, c,
                        out0[r][c], expv[r][c]);
            end
         end
   endtask

   initial begin
      reset  = 1'b1;
      start0 = 1'b0;
      start8 = 1'b0;
      fill_const(0, 0);
      test_reset();
      test_ones();
      test_identity();
      test_saturation();
      test_frac();
      test_random();
      test_back_to_back();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
